// File: rtl/bep_frame_readout.sv
// Frame snapshot sequencer: freezes the decoder, copies the mux bytes into a local buffer, then streams them to the host.
// Optional BEP_STATUS_BYTE_EN appends the validation byte (mux address 15) to every snapshot.
module bep_frame_readout #(
    parameter int unsigned FRAME_BYTES = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_valid,
    input  logic [7:0] mux_data,
    output logic [3:0] mux_address,
    output logic       rx_enable,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       flush,
    output logic       overrun,
    input  logic       overrun_clear,
    output logic [7:0] frame_count
);

`ifdef BEP_STATUS_BYTE_EN
    localparam int unsigned NBYTES = FRAME_BYTES + 1;
`else
    localparam int unsigned NBYTES = FRAME_BYTES;
`endif
    localparam logic [3:0] LAST_IDX  = 4'(NBYTES - 1);
    localparam logic [3:0] LAST_DATA = 4'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_STREAM
    } state_e;

    state_e     state_q;
    logic       frame_valid_q;
    logic [3:0] idx_q;
    logic [3:0] rd_q;
    logic [3:0] mux_address_q;
    logic       rx_enable_q;
    logic [7:0] out_data_q;
    logic       out_valid_q;
    logic       overrun_q;
    logic [7:0] frame_count_q;
    logic [7:0] snap_q [NBYTES];

    logic       frame_edge;
    logic [3:0] idx_d;
    logic [3:0] rd_d;

    always_comb begin
        frame_edge = frame_valid & ~frame_valid_q;
        idx_d      = idx_q + 4'd1;
        rd_d       = rd_q + 4'd1;
    end

    always_ff @(posedge clock) begin
        if (state_q == S_CAPTURE) begin
            snap_q[idx_q] <= mux_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            frame_valid_q <= 1'b1;
            idx_q         <= '0;
            rd_q          <= '0;
            mux_address_q <= '0;
            rx_enable_q   <= 1'b1;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            frame_valid_q <= frame_valid;

            // A new overrun in the same cycle as the clear keeps the flag set
            if (frame_edge && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (overrun_clear) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    mux_address_q <= '0;
                    rx_enable_q   <= 1'b1;
                    out_valid_q   <= 1'b0;
                    if (frame_edge) begin
                        state_q     <= S_CAPTURE;
                        idx_q       <= '0;
                        rx_enable_q <= 1'b0;
                    end
                end

                S_CAPTURE: begin
                    if (idx_q == LAST_IDX) begin
                        state_q       <= S_STREAM;
                        rd_q          <= '0;
                        mux_address_q <= '0;
                        out_valid_q   <= 1'b1;
                        // Single-byte snapshot: byte 0 is still being written, so take it straight from the mux
                        out_data_q    <= (idx_q == 4'd0) ? mux_data : snap_q[0];
                    end else begin
                        idx_q         <= idx_d;
                        mux_address_q <= (idx_d > LAST_DATA) ? 4'hF : idx_d;
                    end
                end

                S_STREAM: begin
                    if (flush) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        rx_enable_q <= 1'b1;
                    end else if (out_ready) begin
                        if (rd_q == LAST_IDX) begin
                            state_q       <= S_IDLE;
                            out_valid_q   <= 1'b0;
                            rx_enable_q   <= 1'b1;
                            frame_count_q <= frame_count_q + 8'd1;
                        end else begin
                            rd_q       <= rd_d;
                            out_data_q <= snap_q[rd_d];
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mux_address = mux_address_q;
    assign rx_enable   = rx_enable_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_bep_frame_readout.sv
// Directed bench for bep_frame_readout: a mux model feeds frames, a scoreboard queue checks every streamed byte.
module tb_bep_frame_readout;

    localparam int FB = 12;
`ifdef BEP_STATUS_BYTE_EN
    localparam int NB = FB + 1;
`else
    localparam int NB = FB;
`endif

    logic       clock;
    logic       reset;
    logic       frame_valid;
    logic [7:0] mux_data;
    logic [3:0] mux_address;
    logic       rx_enable;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       flush;
    logic       overrun;
    logic       overrun_clear;
    logic [7:0] frame_count;

    bep_frame_readout #(.FRAME_BYTES(FB)) dut (
        .clock         (clock),
        .reset         (reset),
        .frame_valid   (frame_valid),
        .mux_data      (mux_data),
        .mux_address   (mux_address),
        .rx_enable     (rx_enable),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .flush         (flush),
        .overrun       (overrun),
        .overrun_clear (overrun_clear),
        .frame_count   (frame_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Mux model: data bytes at A0+addr, validation byte at address 15
    always_comb mux_data = (mux_address == 4'hF) ? 8'h05 : (8'hA0 + {4'h0, mux_address});

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_xfer   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_count;
    logic       stall_prev = 1'b0;
    logic [7:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Stream monitor: sampled on the falling edge, ahead of the transferring rising edge
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            chk("stream_rx_low", rx_enable, 1'b0);
            if (stall_prev) chk("stall_hold", out_data, held);
            if (out_ready) begin
                n_xfer++;
                stall_prev = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 1'b1, 1'b0);
                end else begin
                    chk("byte", out_data, exp_q.pop_front());
                end
            end else begin
                stall_prev = 1'b1;
                held       = out_data;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // mode 0: always ready; mode 1: ready pattern 1,0,0,...
    // edge_at / flush_at: transfer count at which to inject a frame edge / flush (-1 = never)
    task automatic run_frame(input int mode, input int edge_at, input int flush_at);
        int   start;
        int   cyc;
        int   fx;
        logic edge_pending;
        logic edge_fired;
        logic flushed;
        for (int k = 0; k < NB; k++) exp_q.push_back((k < FB) ? (8'hA0 + 8'(k)) : 8'h05);
        start        = n_xfer;
        edge_pending = 1'b0;
        edge_fired   = 1'b0;
        flushed      = 1'b0;
        out_ready    = 1'b0;
        step();
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        for (int k = 0; k < NB; k++) begin
            chk("cap_addr", mux_address, (k < FB) ? k : 15);
            chk("cap_rx", rx_enable, 1'b0);
            step();
        end
        chk("first_valid", out_valid, 1'b1);
        cyc = 0;
        while ((out_valid || exp_q.size() != 0) && cyc < 400 && !flushed) begin
            fx = n_xfer - start;
            if (edge_pending) begin
                frame_valid  = 1'b0;
                edge_pending = 1'b0;
                chk("overrun_set", overrun, 1'b1);
            end
            if (flush_at >= 0 && fx == flush_at) begin
                flush     = 1'b1;
                out_ready = 1'b0;
                step();
                flush   = 1'b0;
                flushed = 1'b1;
                exp_q.delete();
                chk("flush_valid", out_valid, 1'b0);
                chk("flush_rx", rx_enable, 1'b1);
                chk("flush_count", frame_count, exp_count);
                chk("flush_addr", mux_address, 0);
            end else begin
                if (edge_at >= 0 && fx == edge_at && !edge_fired) begin
                    frame_valid  = 1'b1;
                    edge_pending = 1'b1;
                    edge_fired   = 1'b1;
                end
                out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
                step();
                cyc++;
            end
        end
        out_ready = 1'b0;
        if (!flushed) begin
            chk("drain_in_budget", (cyc < 400), 1'b1);
            chk("drained", exp_q.size(), 0);
            chk("xfer_total", n_xfer - start, NB);
            chk("end_valid", out_valid, 1'b0);
            chk("end_rx", rx_enable, 1'b1);
            exp_count = exp_count + 8'd1;
            chk("frame_count", frame_count, exp_count);
        end
    endtask

    initial begin
        reset         = 1'b1;
        frame_valid   = 1'b0;
        out_ready     = 1'b0;
        flush         = 1'b0;
        overrun_clear = 1'b0;
        exp_count     = 8'd0;
        repeat (3) step();
        reset = 1'b0;
        repeat (20) step();
        chk("rst_rx", rx_enable, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_addr", mux_address, 0);
        chk("rst_count", frame_count, 0);
        chk("rst_overrun", overrun, 1'b0);

        // Plain frame, always ready
        run_frame(0, -1, -1);
        // Stalling host
        run_frame(1, -1, -1);
        // Frame edge while streaming byte 5
        run_frame(0, 5, -1);
        chk("overrun_held", overrun, 1'b1);
        step();
        overrun_clear = 1'b1;
        step();
        overrun_clear = 1'b0;
        chk("overrun_cleared", overrun, 1'b0);
        // Flush after 3 transfers, then a normal frame
        run_frame(0, -1, 3);
        repeat (2) step();
        chk("post_flush_idle", out_valid, 1'b0);
        run_frame(0, -1, -1);

        // frame_valid high through reset release is not a frame
        frame_valid = 1'b1;
        reset       = 1'b1;
        repeat (2) step();
        reset     = 1'b0;
        exp_count = 8'd0;
        repeat (5) step();
        chk("hold_rx", rx_enable, 1'b1);
        chk("hold_valid", out_valid, 1'b0);
        chk("hold_addr", mux_address, 0);
        chk("hold_count", frame_count, 0);
        frame_valid = 1'b0;
        step();

        // 256 completed frames wrap the counter
        for (int i = 0; i < 256; i++) run_frame(0, -1, -1);
        chk("wrap_count", frame_count, 0);
        chk("wrap_overrun", overrun, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bep_frame_readout.md
Name: bep_frame_readout

Overview:
- Sequencer between the thermostat packet decoder/mux and the host microcontroller.
- On each newly decoded frame it freezes reception and walks the mux byte address 0..FRAME_BYTES-1, snapshotting every byte into a local buffer.
- It then streams the snapshot to the host over a valid/ready byte handshake and re-enables reception when the frame is drained or flushed.

Parameters:
- FRAME_BYTES, 12, bytes captured per frame from mux addresses 0..FRAME_BYTES-1; legal range 1..15.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- frame_valid  input  1  decoder frame-valid level from the mux block.
- mux_data  input  8  combinational mux byte for the current mux_address.
- mux_address  output  4  byte select driven into the mux.
- rx_enable  output  1  high = decoder may accept serial data; low = frozen.
- out_data  output  8  streamed snapshot byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  host accepts out_data this cycle.
- flush  input  1  host abandons the current stream.
- overrun  output  1  sticky: a frame edge arrived while busy.
- overrun_clear  input  1  clears overrun.
- frame_count  output  8  completed frames, wraps 255->0.

Behaviour:
- Reset values:
  - state IDLE; mux_address=0; rx_enable=1; out_valid=0; out_data=0; overrun=0; frame_count=0.
  - frame_valid edge register=1, so a level already high at reset release is not a frame.
  - Buffer contents are don't-care.
- Edge detect: frame_edge = frame_valid & ~frame_valid_q. frame_valid_q is registered every cycle.
- IDLE:
  - rx_enable=1, mux_address=0, out_valid=0.
  - frame_edge in cycle N -> CAPTURE from cycle N+1, idx=0, rx_enable=0 from N+1.
- CAPTURE:
  - mux_address=idx. Each cycle buf[idx]<=mux_data (same-cycle combinational read), idx++.
  - After idx=FRAME_BYTES-1 is stored -> STREAM, rd=0.
  - Duration is exactly FRAME_BYTES cycles; flush is ignored in this state.
- STREAM:
  - out_valid=1, out_data=buf[rd] (registered output, stable while out_ready=0).
  - Transfer occurs when out_valid & out_ready; then rd++.
  - Transfer of the last byte -> IDLE next cycle, with out_valid=0, rx_enable=1 and frame_count+1.
  - flush=1 (with or without a transfer) -> IDLE next cycle; frame_count is not incremented.
  - First out_valid occurs in cycle N+1+FRAME_BYTES after the edge cycle N.
- Overrun:
  - frame_edge in CAPTURE or STREAM: the frame is dropped and overrun<=1.
  - The same cycle as the IDLE-bound transition also counts as busy.
  - overrun_clear=1 clears it; if a new overrun occurs in the same cycle, the set wins.
- frame_count is modulo 256.
- mux_address stays within 0..FRAME_BYTES-1 except under STATUS_BYTE_EN.
- A mid-operation reset returns to IDLE on the next edge and discards the snapshot and stream position.

Optional Feature:
- Macro: BEP_STATUS_BYTE_EN.
- Defined:
  - After byte FRAME_BYTES-1, CAPTURE spends one extra cycle with mux_address=15 and stores the validation byte as buf[FRAME_BYTES].
  - The stream is FRAME_BYTES+1 bytes; the status byte is last.
  - First out_valid moves to cycle N+2+FRAME_BYTES.
- Undefined:
  - Address 15 is never driven; the stream is FRAME_BYTES bytes.

Test Plan:
- Reset, frame_valid held 0, run 20 cycles -> rx_enable=1, out_valid=0, mux_address=0, frame_count=0.
- Mux model returns 8'hA0+addr; pulse frame_valid; out_ready=1 -> mux_address steps 0..11 over 12 cycles; stream delivers A0..AB in order; rx_enable low throughout, high after; frame_count=1.
- Same frame with out_ready toggling 1,0,0,1... -> out_data holds during stalls; every byte delivered exactly once; total of 12 transfers.
- Second frame_valid edge while streaming byte 5 -> overrun=1; stream completes unchanged; overrun_clear -> 0; only 1 frame counted.
- flush asserted after 3 transfers -> IDLE next cycle, out_valid=0, rx_enable=1, frame_count unchanged; a following edge captures normally.
- frame_valid high through reset release -> no capture; 256 completed frames -> frame_count wraps to 0.
- With BEP_STATUS_BYTE_EN, mux returns 8'h05 at address 15 -> mux_address 15 appears after address 11; 13th byte streamed = 8'h05.
